// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the mem_resp memory responder.
//   mem_state_e : serving engine state (idle / busy)
//   mem_port_e  : tag of the port that owns the in-flight request
//   mem_req_t   : captured request (byte address, store flag, data, lanes)
//   lane_merge  : byte-lane merge of store data into an existing word
package mem_pkg;

  typedef enum logic {
    MS_IDLE,
    MS_BUSY
  } mem_state_e;

  typedef enum logic {
    PORT_IFU,
    PORT_LSU
  } mem_port_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  // Wide enough for LATENCY-1 (max 14) plus up to 3 random extra cycles.
  localparam int unsigned CNT_W = 5;

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wmask);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wmask[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port word RAM, synchronous byte-lane write,
// combinational read. Kept as its own module so the array can later be
// swapped for an SRAM macro. Contents are not reset.
//   clock : rising-edge clock
//   we    : write enable (masked by wmask per byte lane)
//   addr  : word index shared by read and write
//   wdata : write data, lane-aligned
//   wmask : byte-lane write enables
//   rdata : word at addr (combinational)
module mem_resp_ram
  import mem_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= lane_merge(mem[addr], wdata, wmask);
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for IFU fetch and LSU load/store request
// pulses. One shared engine serves both ports; each port has a one-deep
// pending slot, LSU wins arbitration over IFU. The operation is performed in
// the accept cycle and a single-cycle response pulse follows LATENCY cycles
// later. Out-of-range accesses read 0, drop writes, set the sticky err flag
// and still respond. A request to a port whose slot is already full is
// dropped and sets err.
// Optional build macro MEM_RESP_RAND_LAT_EN: a 16-bit LFSR adds 0..3 random
// cycles to LATENCY at each accept.
//   clock, reset_n (async active-low)
//   ifu_reqValid/ifu_addr -> ifu_respValid/ifu_rdata
//   lsu_reqValid/lsu_wen/lsu_addr/lsu_wdata/lsu_wmask -> lsu_respValid/lsu_rdata
//   err : sticky error flag, cleared only by reset
module mem_resp
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        err
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_load;
  mem_port_e        tag_q, tag_d;
  logic             wen_q, wen_d;
  logic [31:0]      data_q, data_d;
  logic             ifu_pv_q, ifu_pv_d, lsu_pv_q, lsu_pv_d;
  mem_req_t         ifu_pend_q, ifu_pend_d, lsu_pend_q, lsu_pend_d;
  logic [31:0]      ifu_hold_q, lsu_hold_q;
  logic             err_q, err_d;

  mem_req_t         ifu_live, lsu_live, sel;
  logic             serve_done, can_accept, acc_lsu, acc_ifu, acc;
  logic [31:0]      off;
  logic             in_range;
  logic             ram_we;
  logic [31:0]      ram_rdata;

`ifdef MEM_RESP_RAND_LAT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign lat_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat_load = CNT_W'(LATENCY - 1);
`endif

  assign ifu_live = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
  assign lsu_live = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};

  // The engine can take a new request when idle, or in the response cycle
  // of the current one (back-to-back service).
  assign serve_done = (state_q == MS_BUSY) && (cnt_q == '0);
  assign can_accept = (state_q == MS_IDLE) || serve_done;

  // Selection kept apart from next-state logic so the address decode below
  // does not feed back into the block that produced it.
  always_comb begin
    acc_lsu = 1'b0;
    acc_ifu = 1'b0;
    sel     = '0;
    if (can_accept) begin
      if (lsu_pv_q || lsu_reqValid) begin
        acc_lsu = 1'b1;
        sel     = lsu_pv_q ? lsu_pend_q : lsu_live;
      end else if (ifu_pv_q || ifu_reqValid) begin
        acc_ifu = 1'b1;
        sel     = ifu_pv_q ? ifu_pend_q : ifu_live;
      end
    end
  end

  assign acc      = acc_lsu || acc_ifu;
  assign off      = sel.addr - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;

  mem_resp_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (off[AW+1:2]),
    .wdata (sel.wdata),
    .wmask (sel.wmask),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    wen_d      = wen_q;
    data_d     = data_q;
    ifu_pv_d   = ifu_pv_q;
    ifu_pend_d = ifu_pend_q;
    lsu_pv_d   = lsu_pv_q;
    lsu_pend_d = lsu_pend_q;
    err_d      = err_q;
    ram_we     = 1'b0;

    // Slots: a full slot at cycle start rejects a new pulse even if the slot
    // is being drained this same cycle.
    if (acc_lsu && lsu_pv_q) lsu_pv_d = 1'b0;
    if (lsu_reqValid) begin
      if (lsu_pv_q) begin
        err_d = 1'b1;
      end else if (!acc_lsu) begin
        lsu_pv_d   = 1'b1;
        lsu_pend_d = lsu_live;
      end
    end

    if (acc_ifu && ifu_pv_q) ifu_pv_d = 1'b0;
    if (ifu_reqValid) begin
      if (ifu_pv_q) begin
        err_d = 1'b1;
      end else if (!acc_ifu) begin
        ifu_pv_d   = 1'b1;
        ifu_pend_d = ifu_live;
      end
    end

    if (acc) begin
      state_d = MS_BUSY;
      cnt_d   = lat_load;
      tag_d   = acc_lsu ? PORT_LSU : PORT_IFU;
      wen_d   = sel.wen;
      ram_we  = sel.wen && in_range;
      if (!in_range) err_d = 1'b1;
      if (!sel.wen) data_d = in_range ? ram_rdata : '0;
    end else if (serve_done) begin
      state_d = MS_IDLE;
    end else if (state_q == MS_BUSY) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MS_IDLE;
      cnt_q      <= '0;
      tag_q      <= PORT_IFU;
      wen_q      <= 1'b0;
      data_q     <= '0;
      ifu_pv_q   <= 1'b0;
      ifu_pend_q <= '0;
      lsu_pv_q   <= 1'b0;
      lsu_pend_q <= '0;
      ifu_hold_q <= '0;
      lsu_hold_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      wen_q      <= wen_d;
      data_q     <= data_d;
      ifu_pv_q   <= ifu_pv_d;
      ifu_pend_q <= ifu_pend_d;
      lsu_pv_q   <= lsu_pv_d;
      lsu_pend_q <= lsu_pend_d;
      err_q      <= err_d;
      if (ifu_respValid)           ifu_hold_q <= data_q;
      if (lsu_respValid && !wen_q) lsu_hold_q <= data_q;
    end
  end

  // Response data is shown live in the response cycle and held afterwards;
  // a store response leaves lsu_rdata at its previous load value.
  assign ifu_respValid = serve_done && (tag_q == PORT_IFU);
  assign lsu_respValid = serve_done && (tag_q == PORT_LSU);
  assign ifu_rdata     = ifu_respValid ? data_q : ifu_hold_q;
  assign lsu_rdata     = (lsu_respValid && !wen_q) ? data_q : lsu_hold_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_resp.sv
module tb_mem_resp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned npulse;

  always #5 clock = ~clock;

  mem_resp #(
    .MEM_WORDS (4096),
    .BASE_ADDR (32'h8000_0000),
    .LATENCY   (2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .err           (err)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    #3;
    reset_n = 1'b1;
    cyc();
  endtask

  // Each op drives a one-cycle pulse; on return the bench is in cycle 1.
  task automatic ifu_op(input logic [31:0] a);
    ifu_reqValid = 1'b1;
    ifu_addr     = a;
    cyc();
    ifu_reqValid = 1'b0;
  endtask

  task automatic lsu_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
    lsu_reqValid = 1'b1;
    lsu_wen      = w;
    lsu_addr     = a;
    lsu_wdata    = d;
    lsu_wmask    = m;
    cyc();
    lsu_reqValid = 1'b0;
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    lsu_op(1'b1, a, d, m);
    chk({tag, "_c1_resp"}, 32'(lsu_respValid), 32'd0);
    cyc();
    chk({tag, "_c2_resp"}, 32'(lsu_respValid), 32'd1);
    cyc();
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    lsu_op(1'b0, a, 32'h0, 4'h0);
    chk({tag, "_c1_resp"}, 32'(lsu_respValid), 32'd0);
    cyc();
    chk({tag, "_c2_resp"}, 32'(lsu_respValid), 32'd1);
    chk({tag, "_rdata"}, lsu_rdata, exp);
    cyc();
  endtask

  initial begin
    reset_n      = 1'b0;
    ifu_reqValid = 1'b0;
    ifu_addr     = '0;
    lsu_reqValid = 1'b0;
    lsu_wen      = 1'b0;
    lsu_addr     = '0;
    lsu_wdata    = '0;
    lsu_wmask    = '0;
    cyc();
    cyc();
    chk("rst_ifu_resp", 32'(ifu_respValid), 32'd0);
    chk("rst_lsu_resp", 32'(lsu_respValid), 32'd0);
    chk("rst_ifu_rdata", ifu_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    #3;
    reset_n = 1'b1;
    cyc();

    // Preload through the store path.
    store("pre0", 32'h8000_0000, 32'h0000_0013, 4'hF);
    store("pre1", 32'h8000_0010, 32'h1111_1111, 4'hF);

    // Fetch: response only in cycle 2, data held afterwards.
    ifu_op(32'h8000_0000);
    chk("f_c1_resp", 32'(ifu_respValid), 32'd0);
    cyc();
    chk("f_c2_resp", 32'(ifu_respValid), 32'd1);
    chk("f_c2_rdata", ifu_rdata, 32'h0000_0013);
    chk("f_c2_lsu", 32'(lsu_respValid), 32'd0);
    cyc();
    chk("f_c3_resp", 32'(ifu_respValid), 32'd0);
    chk("f_c3_hold", ifu_rdata, 32'h0000_0013);

    // Masked store then load.
    store("st_mask", 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011);
    load("ld_mask", 32'h8000_0010, 32'h1111_BEEF);

    // Zero-mask store still responds, RAM unchanged.
    store("st_zero", 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
    load("ld_zero", 32'h8000_0010, 32'h1111_BEEF);

    // Last in-range word.
    store("st_last", 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF);
    load("ld_last", 32'h8000_3FFC, 32'hA5A5_5A5A);
    chk("last_err", 32'(err), 32'd0);

    // Simultaneous IFU and LSU: LSU at +2, IFU at +4.
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h8000_0000;
    lsu_op(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    ifu_reqValid = 1'b0;
    chk("sim_c1_any", 32'({ifu_respValid, lsu_respValid}), 32'd0);
    cyc();
    chk("sim_c2_lsu", 32'(lsu_respValid), 32'd1);
    chk("sim_c2_ifu", 32'(ifu_respValid), 32'd0);
    chk("sim_c2_rdata", lsu_rdata, 32'h1111_BEEF);
    cyc();
    chk("sim_c3_any", 32'({ifu_respValid, lsu_respValid}), 32'd0);
    cyc();
    chk("sim_c4_ifu", 32'(ifu_respValid), 32'd1);
    chk("sim_c4_lsu", 32'(lsu_respValid), 32'd0);
    chk("sim_c4_rdata", ifu_rdata, 32'h0000_0013);
    chk("sim_err", 32'(err), 32'd0);
    cyc();

    // Below BASE_ADDR: reads 0, sets sticky err.
    load("ld_low", 32'h0000_0100, 32'h0);
    chk("low_err", 32'(err), 32'd1);
    cyc();
    cyc();
    chk("low_err_sticky", 32'(err), 32'd1);

    // One past the end: write dropped, no aliasing onto word 0.
    do_reset();
    chk("rst2_err", 32'(err), 32'd0);
    store("st_high", 32'h8000_4000, 32'hFFFF_FFFF, 4'hF);
    chk("high_err", 32'(err), 32'd1);
    load("ld_w0", 32'h8000_0000, 32'h0000_0013);

    // Three consecutive IFU pulses: first served, second latched, third dropped.
    do_reset();
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h8000_0000;
    cyc();
    ifu_addr     = 32'h8000_0010;
    chk("ov_c1_resp", 32'(ifu_respValid), 32'd0);
    cyc();
    chk("ov_c2_resp", 32'(ifu_respValid), 32'd1);
    chk("ov_c2_rdata", ifu_rdata, 32'h0000_0013);
    chk("ov_c2_err", 32'(err), 32'd0);
    ifu_addr     = 32'h8000_3FFC;
    cyc();
    ifu_reqValid = 1'b0;
    chk("ov_c3_resp", 32'(ifu_respValid), 32'd0);
    chk("ov_c3_err", 32'(err), 32'd1);
    cyc();
    chk("ov_c4_resp", 32'(ifu_respValid), 32'd1);
    chk("ov_c4_rdata", ifu_rdata, 32'h1111_BEEF);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ifu_respValid) npulse++;
    end
    chk("ov_extra_pulses", npulse, 32'd0);

    // Reset between accept and response.
    ifu_op(32'h8000_0000);
    reset_n = 1'b0;
    #1;
    chk("mid_ifu_resp", 32'(ifu_respValid), 32'd0);
    chk("mid_ifu_rdata", ifu_rdata, 32'h0);
    chk("mid_err", 32'(err), 32'd0);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ifu_respValid || lsu_respValid) npulse++;
    end
    chk("mid_no_resp", npulse, 32'd0);
    ifu_op(32'h8000_0010);
    chk("post_c1_resp", 32'(ifu_respValid), 32'd0);
    cyc();
    chk("post_c2_resp", 32'(ifu_respValid), 32'd1);
    chk("post_c2_rdata", ifu_rdata, 32'h1111_BEEF);
    chk("post_err", 32'(err), 32'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the core's fetch/load/store request pulses.
- Owns a word-addressed instruction/data RAM and returns single-cycle response pulses after a fixed latency.
- Serves two request ports, IFU (read-only) and LSU (read/write), through one shared serving engine.
- Sits between the core control state machine and on-chip memory; replaces the testbench memory model in the SoC.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request-accept cycle to respValid cycle; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ifu_reqValid  in  1  single-cycle fetch request pulse
- ifu_addr  in  32  fetch byte address, valid with ifu_reqValid
- ifu_respValid  out  1  single-cycle fetch response pulse
- ifu_rdata  out  32  fetched word, valid with ifu_respValid
- lsu_reqValid  in  1  single-cycle load/store request pulse
- lsu_wen  in  1  1 = store, 0 = load; valid with lsu_reqValid
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, lane-aligned
- lsu_wmask  in  4  byte-lane write enables
- lsu_respValid  out  1  single-cycle load/store response pulse
- lsu_rdata  out  32  full loaded word (the core extracts byte/half)
- err  out  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; pending slots empty; counter 0; err 0. RAM contents are not reset.
- Index: idx = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
- In range when (addr - BASE_ADDR) < MEM_WORDS*4 (unsigned). Out of range: reads return 0, writes are dropped, err is set, and a response is still given.
- Engine FSM states:
  - IDLE: on accept, go to BUSY with counter = LATENCY-1, port tag recorded, and the operation performed in the accept cycle. A store commits masked bytes to RAM; a load or fetch captures the word into a data register.
  - BUSY: counter decrements each cycle. When the counter reaches 0, the response for the tagged port is driven for exactly that cycle. The engine then returns to IDLE, or, if a pending slot is full, accepts it in that same cycle (back-to-back service).
  - With LATENCY=1, the response appears in the cycle after the accept cycle.
- Arbitration: each port has one one-deep pending slot. A request arriving while the engine is BUSY, or losing arbitration, is latched into its slot. On simultaneous candidates, LSU wins over IFU.
- Overflow: a new request on a port whose slot is already full is dropped and sets err. err clears only on reset.
- A store with lsu_wmask = 0 still responds; RAM is unchanged.
- Load after store: a load accepted after a store's accept cycle sees the new data.
- rdata outputs hold their last value between responses.
- respValid is never asserted on both ports in the same cycle.
- Reset mid-operation: in-flight and pending requests are discarded and no response is produced.

Optional Feature:
- Macro: MEM_RESP_RAND_LAT_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. At each accept, LFSR[1:0] extra cycles (0..3) are added to LATENCY. Purpose: stress the core's handshake.
- Undefined: fixed LATENCY; no LFSR logic is present.

Decomposition:
- Shared package mem_pkg:
  - engine state enum (MS_IDLE, MS_BUSY)
  - port tag enum (PORT_IFU, PORT_LSU)
  - request struct {addr, wen, wdata, wmask}
  - function lane_merge(old, wdata, wmask)
- One sub-module, mem_resp_ram: single-port synchronous-write, combinational-read word RAM with byte-lane enables. It keeps the memory array isolated for later SRAM-macro substitution.

Test Plan:
- LATENCY=2: ifu_reqValid at cycle 0, addr 32'h8000_0000 (preloaded 32'h0000_0013) -> ifu_respValid high only at cycle 2, ifu_rdata=32'h0000_0013.
- Store addr 32'h8000_0010, wdata 32'hDEAD_BEEF, wmask 4'b0011 onto word 32'h1111_1111 -> lsu_respValid after 2 cycles. A following load of the same address returns 32'h1111_BEEF.
- IFU and LSU requests in the same cycle -> LSU response at +2, IFU response at +4, no overlap, err=0.
- Load from 32'h0000_0100 (below BASE_ADDR) -> lsu_respValid at +2, lsu_rdata=0, err=1 and stays 1.
- While BUSY, three IFU pulses on consecutive cycles -> first pulse served, second latched, third dropped; two ifu_respValid pulses total, err=1.
- reset_n driven low for one cycle between accept and response -> no respValid afterwards, all outputs 0 immediately. A fresh request after release behaves normally.
